// File: rtl/ex_pkg.sv
// Shared definitions for the RV32I execute stage: ALUop encodings, funct3
// constants, ALU control codes, multiplier FSM states and the ALU decoder.
package ex_pkg;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_MUL  = 3'b000;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_ctl_t;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  // Immediate ALU ops reuse the R-type decode, except that inst[30] is part
  // of the immediate and only matters for the arithmetic right shift.
  function automatic alu_ctl_t decodeAluCtl(input logic [1:0] aluOp,
                                            input logic inst30,
                                            input logic [2:0] funct3);
    alu_ctl_t ctl;
    ctl = ALU_ADD;
    case (aluOp)
      ALUOP_MEM:    ctl = ALU_ADD;
      ALUOP_BRANCH: ctl = ALU_SUB;
      default: begin
        case (funct3)
          F3_ADD:  ctl = (aluOp == ALUOP_RTYPE && inst30) ? ALU_SUB : ALU_ADD;
          F3_SLL:  ctl = ALU_SLL;
          F3_SLT:  ctl = ALU_SLT;
          F3_SLTU: ctl = ALU_SLTU;
          F3_XOR:  ctl = ALU_XOR;
          F3_SR:   ctl = inst30 ? ALU_SRA : ALU_SRL;
          F3_OR:   ctl = ALU_OR;
          default: ctl = ALU_AND;
        endcase
      end
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/alu_unit.sv
// Combinational RV32I ALU. All arithmetic wraps modulo 2^XLEN; shift amount
// comes from b[4:0]; zero flags an all-zero result for branch compares.
module alu_unit
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_ctl_t          ctl,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   result,
  output logic              zero
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  // Select the operation result.
  always_comb begin
    result = '0;
    case (ctl)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $signed(a) >>> shamt;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// EX stage of the 5-stage RV32I pipeline: operand forwarding, ALU control,
// ALU, branch resolution and the EX/MEM pipeline register.
// Optional iterative multiplier enabled by defining EX_MUL_EN.
// Handshake: stallE is a combinational hold request; while it is high the
// upstream stages keep the ID/EX bundle stable and EX/MEM receives bubbles.
// mulStateDebug shows the multiplier FSM state (always 0 without EX_MUL_EN).
module execute_stage
  import ex_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ALUscrE,
  input  logic            memToRegE,
  input  logic            regWriteE,
  input  logic            memReadE,
  input  logic            memWriteE,
  input  logic            branchE,
  input  logic [1:0]      ALUopE,
  input  logic [4:0]      functE,
  input  logic [4:0]      write_regE,
  input  logic [4:0]      read_regE1,
  input  logic [4:0]      read_regE2,
  input  logic [XLEN-1:0] read_dataE1,
  input  logic [XLEN-1:0] read_dataE2,
  input  logic [XLEN-1:0] PC_E,
  input  logic [XLEN-1:0] GenOutE,
  input  logic            regWriteW,
  input  logic [4:0]      write_regW,
  input  logic [XLEN-1:0] write_dataW,
  output logic            memToRegM,
  output logic            regWriteM,
  output logic            memReadM,
  output logic            memWriteM,
  output logic [XLEN-1:0] ALU_resultM,
  output logic [XLEN-1:0] store_dataM,
  output logic [4:0]      write_regM,
  output logic            PCSrcM,
  output logic [XLEN-1:0] PC_branchM,
  output logic            stallE,
  output logic [1:0]      mulStateDebug
);

  logic [XLEN-1:0] fwdA;
  logic [XLEN-1:0] fwdB;
  logic [XLEN-1:0] srcB;
  logic [XLEN-1:0] aluResult;
  logic [XLEN-1:0] resultSel;
  logic [XLEN-1:0] branchTarget;
  logic            aluZero;
  logic            branchTaken;
  logic            bubble;
  alu_ctl_t        aluCtl;

  // Forwarding: the younger EX/MEM result wins over writeback; x0 never forwards.
  always_comb begin
    fwdA = read_dataE1;
    if (regWriteM && write_regM == read_regE1 && read_regE1 != 5'd0)
      fwdA = ALU_resultM;
    else if (regWriteW && write_regW == read_regE1 && read_regE1 != 5'd0)
      fwdA = write_dataW;

    fwdB = read_dataE2;
    if (regWriteM && write_regM == read_regE2 && read_regE2 != 5'd0)
      fwdB = ALU_resultM;
    else if (regWriteW && write_regW == read_regE2 && read_regE2 != 5'd0)
      fwdB = write_dataW;
  end

  assign srcB   = ALUscrE ? GenOutE : fwdB;
  assign aluCtl = decodeAluCtl(ALUopE, functE[4], functE[2:0]);

  alu_unit #(.XLEN(XLEN)) u_alu (
    .ctl    (aluCtl),
    .a      (fwdA),
    .b      (srcB),
    .result (aluResult),
    .zero   (aluZero)
  );

  // Only BEQ and BNE are resolved here; other funct3 codes fall through.
  always_comb begin
    branchTaken = 1'b0;
    if (branchE) begin
      if (functE[2:0] == F3_BEQ)
        branchTaken = aluZero;
      else if (functE[2:0] == F3_BNE)
        branchTaken = !aluZero;
    end
  end

  assign branchTarget = PC_E + (GenOutE << 1);

`ifdef EX_MUL_EN
  localparam int CNT_W = $clog2(MUL_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_CYCLES - 1);

  mul_state_t      state;
  mul_state_t      nextState;
  logic            mulValid;
  logic            mulStart;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] product;
  logic [CNT_W-1:0] iterCount;

  assign mulValid = (ALUopE == ALUOP_RTYPE) && functE[3] && (functE[2:0] == F3_MUL);

  // Multiplier FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) state <= MUL_IDLE;
    else        state <= nextState;
  end

  // Multiplier FSM next state and stall request; a MUL in a squashed slot never starts.
  always_comb begin
    nextState = state;
    stallE    = 1'b0;
    mulStart  = 1'b0;
    case (state)
      MUL_IDLE: begin
        if (mulValid && !PCSrcM) begin
          nextState = MUL_BUSY;
          stallE    = 1'b1;
          mulStart  = 1'b1;
        end
      end
      MUL_BUSY: begin
        stallE = 1'b1;
        if (iterCount == LAST_ITER) nextState = MUL_DONE;
      end
      MUL_DONE: nextState = MUL_IDLE;
      default:  nextState = MUL_IDLE;
    endcase
  end

  // Shift-add datapath: one multiplier bit per BUSY cycle, low XLEN bits kept.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mcand     <= '0;
      mplier    <= '0;
      product   <= '0;
      iterCount <= '0;
    end else if (mulStart) begin
      mcand     <= fwdA;
      mplier    <= fwdB;
      product   <= '0;
      iterCount <= '0;
    end else if (state == MUL_BUSY) begin
      if (mplier[0]) product <= product + mcand;
      mcand     <= mcand << 1;
      mplier    <= mplier >> 1;
      iterCount <= iterCount + 1'b1;
    end
  end

  assign resultSel     = (state == MUL_DONE) ? product : aluResult;
  assign mulStateDebug = state;
`else
  logic unusedMulBit;
  assign unusedMulBit  = functE[3];
  assign stallE        = 1'b0;
  assign resultSel     = aluResult;
  assign mulStateDebug = 2'b00;
`endif

  assign bubble = PCSrcM || stallE;

  // EX/MEM register; a squashed or stalled slot carries no control.
  always_ff @(posedge clock) begin
    if (!reset) begin
      memToRegM   <= 1'b0;
      regWriteM   <= 1'b0;
      memReadM    <= 1'b0;
      memWriteM   <= 1'b0;
      ALU_resultM <= '0;
      store_dataM <= '0;
      write_regM  <= 5'd0;
      PCSrcM      <= 1'b0;
      PC_branchM  <= '0;
    end else begin
      ALU_resultM <= resultSel;
      store_dataM <= fwdB;
      write_regM  <= write_regE;
      PC_branchM  <= branchTarget;
      if (bubble) begin
        memToRegM <= 1'b0;
        regWriteM <= 1'b0;
        memReadM  <= 1'b0;
        memWriteM <= 1'b0;
        PCSrcM    <= 1'b0;
      end else begin
        memToRegM <= memToRegE;
        regWriteM <= regWriteE;
        memReadM  <= memReadE;
        memWriteM <= memWriteE;
        PCSrcM    <= branchTaken;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage: reset, ALU, forwarding, branch/squash,
// back-to-back dependencies and (with EX_MUL_EN) the iterative multiplier.
module tb_execute_stage;

  localparam int XLEN       = 32;
  localparam int MUL_CYCLES = 32;

  logic            clock;
  logic            reset;
  logic            ALUscrE, memToRegE, regWriteE, memReadE, memWriteE, branchE;
  logic [1:0]      ALUopE;
  logic [4:0]      functE, write_regE, read_regE1, read_regE2;
  logic [XLEN-1:0] read_dataE1, read_dataE2, PC_E, GenOutE;
  logic            regWriteW;
  logic [4:0]      write_regW;
  logic [XLEN-1:0] write_dataW;
  logic            memToRegM, regWriteM, memReadM, memWriteM;
  logic [XLEN-1:0] ALU_resultM, store_dataM, PC_branchM;
  logic [4:0]      write_regM;
  logic            PCSrcM, stallE;
  logic [1:0]      mulStateDebug;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [4:0]  funct;
    logic        src;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] exp;
  } alu_vec_t;

  execute_stage #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clock(clock), .reset(reset), .ALUscrE(ALUscrE), .memToRegE(memToRegE),
    .regWriteE(regWriteE), .memReadE(memReadE), .memWriteE(memWriteE),
    .branchE(branchE), .ALUopE(ALUopE), .functE(functE), .write_regE(write_regE),
    .read_regE1(read_regE1), .read_regE2(read_regE2), .read_dataE1(read_dataE1),
    .read_dataE2(read_dataE2), .PC_E(PC_E), .GenOutE(GenOutE),
    .regWriteW(regWriteW), .write_regW(write_regW), .write_dataW(write_dataW),
    .memToRegM(memToRegM), .regWriteM(regWriteM), .memReadM(memReadM),
    .memWriteM(memWriteM), .ALU_resultM(ALU_resultM), .store_dataM(store_dataM),
    .write_regM(write_regM), .PCSrcM(PCSrcM), .PC_branchM(PC_branchM),
    .stallE(stallE), .mulStateDebug(mulStateDebug)
  );

  // Clock generation.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task step;
    @(posedge clock);
    #1;
  endtask

  task set_nop;
    ALUscrE = 0; memToRegE = 0; regWriteE = 0; memReadE = 0; memWriteE = 0;
    branchE = 0; ALUopE = 2'b00; functE = 5'd0; write_regE = 5'd0;
    read_regE1 = 5'd0; read_regE2 = 5'd0; read_dataE1 = '0; read_dataE2 = '0;
    PC_E = '0; GenOutE = '0; regWriteW = 0; write_regW = 5'd0; write_dataW = '0;
  endtask

  task drive_op(input logic [1:0] op, input logic [4:0] funct, input logic srcImm,
                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
    set_nop;
    ALUopE = op; functE = funct; ALUscrE = srcImm; regWriteE = 1'b1;
    write_regE = rd; read_regE1 = rs1; read_regE2 = rs2;
    read_dataE1 = d1; read_dataE2 = d2; GenOutE = imm;
  endtask

  task test_reset;
    reset = 1'b0;
    drive_op(2'b10, 5'b00000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 32'd4);
    memToRegE = 1; memReadE = 1; memWriteE = 1; PC_E = 32'h40;
    step;
    compared++;
    if ({memToRegM, regWriteM, memReadM, memWriteM, PCSrcM} !== 5'b0) begin
      $display("FAIL reset_ctl: got %b expected 00000", {memToRegM, regWriteM, memReadM, memWriteM, PCSrcM});
      mismatched++;
    end
    compared++;
    if (ALU_resultM !== 32'd0 || store_dataM !== 32'd0 || PC_branchM !== 32'd0 || write_regM !== 5'd0) begin
      $display("FAIL reset_data: got res=%h st=%h pc=%h rd=%0d expected all 0", ALU_resultM, store_dataM, PC_branchM, write_regM);
      mismatched++;
    end
    compared++;
    if (stallE !== 1'b0) begin
      $display("FAIL reset_stall: got %b expected 0", stallE);
      mismatched++;
    end
    reset = 1'b1;
    memToRegE = 0; memReadE = 0; memWriteE = 0;
    step;
    compared++;
    if (ALU_resultM !== 32'd12 || regWriteM !== 1'b1) begin
      $display("FAIL reset_release: got res=%h wr=%b expected 0000000c 1", ALU_resultM, regWriteM);
      mismatched++;
    end
    set_nop;
    step;
  endtask

  task test_add;
    drive_op(2'b10, 5'b00000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0);
    step;
    compared++;
    if (ALU_resultM !== 32'd12 || write_regM !== 5'd3 || regWriteM !== 1'b1 || store_dataM !== 32'd7) begin
      $display("FAIL add: got res=%h rd=%0d wr=%b st=%h expected 0000000c 3 1 00000007", ALU_resultM, write_regM, regWriteM, store_dataM);
      mismatched++;
    end
    set_nop;
    step;
  endtask

  task test_forwarding;
    // x5 <- 0xAA into EX/MEM
    drive_op(2'b10, 5'b00000, 1'b0, 5'd5, 5'd0, 5'd0, 32'hAA, 32'h0, 32'h0);
    step;
    // rs1=x5 matches M (0xAA) and W (0xBB): M must win
    drive_op(2'b10, 5'b00000, 1'b0, 5'd6, 5'd5, 5'd7, 32'h11, 32'h0, 32'h0);
    regWriteW = 1; write_regW = 5'd5; write_dataW = 32'hBB;
    step;
    compared++;
    if (ALU_resultM !== 32'hAA) begin
      $display("FAIL fwd_m_over_w: got %h expected 000000aa", ALU_resultM);
      mismatched++;
    end
    // M now holds x6=0xAA; rs1=x5 from W (0xBB), rs2=x6 from M (0xAA)
    drive_op(2'b10, 5'b00000, 1'b0, 5'd9, 5'd5, 5'd6, 32'h11, 32'h3, 32'h0);
    regWriteW = 1; write_regW = 5'd5; write_dataW = 32'hBB;
    step;
    compared++;
    if (ALU_resultM !== 32'h165 || store_dataM !== 32'hAA) begin
      $display("FAIL fwd_w_and_store: got res=%h st=%h expected 00000165 000000aa", ALU_resultM, store_dataM);
      mismatched++;
    end
    // x0 written with regWrite set must never forward
    drive_op(2'b10, 5'b00000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h55, 32'h0, 32'h0);
    step;
    drive_op(2'b10, 5'b00000, 1'b0, 5'd10, 5'd0, 5'd0, 32'h22, 32'h1, 32'h0);
    regWriteW = 1; write_regW = 5'd0; write_dataW = 32'h99;
    step;
    compared++;
    if (ALU_resultM !== 32'h23) begin
      $display("FAIL fwd_x0: got %h expected 00000023", ALU_resultM);
      mismatched++;
    end
    set_nop;
    step;
  endtask

  task test_back_to_back;
    drive_op(2'b10, 5'b00000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 32'd2, 32'd0);
    step;
    drive_op(2'b10, 5'b00000, 1'b0, 5'd2, 5'd1, 5'd1, 32'd0, 32'd0, 32'd0);
    step;
    compared++;
    if (ALU_resultM !== 32'd6) begin
      $display("FAIL b2b_dep1: got %h expected 00000006", ALU_resultM);
      mismatched++;
    end
    drive_op(2'b10, 5'b00000, 1'b0, 5'd3, 5'd2, 5'd1, 32'd0, 32'd0, 32'd0);
    regWriteW = 1; write_regW = 5'd1; write_dataW = 32'd3;
    step;
    compared++;
    if (ALU_resultM !== 32'd9 || write_regM !== 5'd3) begin
      $display("FAIL b2b_dep2: got res=%h rd=%0d expected 00000009 3", ALU_resultM, write_regM);
      mismatched++;
    end
    set_nop;
    step;
  endtask

  task test_branch;
    set_nop;
    ALUopE = 2'b01; branchE = 1; functE = 5'b00000;
    read_regE1 = 5'd8; read_regE2 = 5'd9; read_dataE1 = 32'h40; read_dataE2 = 32'h40;
    PC_E = 32'h100; GenOutE = 32'd8;
    step;
    compared++;
    if (PCSrcM !== 1'b1 || PC_branchM !== 32'h110 || regWriteM !== 1'b0) begin
      $display("FAIL beq_taken: got src=%b tgt=%h wr=%b expected 1 00000110 0", PCSrcM, PC_branchM, regWriteM);
      mismatched++;
    end
    // wrong-path slot: would-be taken branch with writes must become a bubble
    regWriteE = 1; memWriteE = 1;
    step;
    compared++;
    if (PCSrcM !== 1'b0 || regWriteM !== 1'b0 || memWriteM !== 1'b0) begin
      $display("FAIL squash: got src=%b wr=%b mw=%b expected 0 0 0", PCSrcM, regWriteM, memWriteM);
      mismatched++;
    end
    regWriteE = 0; memWriteE = 0;
    read_dataE2 = 32'h41;
    step;
    compared++;
    if (PCSrcM !== 1'b0) begin
      $display("FAIL beq_not_taken: got %b expected 0", PCSrcM);
      mismatched++;
    end
    functE = 5'b00001; PC_E = 32'h200; GenOutE = 32'hFFFF_FFFC;
    step;
    compared++;
    if (PCSrcM !== 1'b1 || PC_branchM !== 32'h1F8) begin
      $display("FAIL bne_taken: got src=%b tgt=%h expected 1 000001f8", PCSrcM, PC_branchM);
      mismatched++;
    end
    set_nop;
    step;
    ALUopE = 2'b01; branchE = 1; functE = 5'b00100;
    read_dataE1 = 32'd1; read_dataE2 = 32'd2;
    step;
    compared++;
    if (PCSrcM !== 1'b0) begin
      $display("FAIL other_f3_not_taken: got %b expected 0", PCSrcM);
      mismatched++;
    end
    set_nop;
    step;
  endtask

  task test_alu_ops;
    alu_vec_t vecs[$];
    vecs.push_back('{"sra",   2'b10, 5'b10101, 1'b0, 32'h8000_0000, 32'd4,  32'd0, 32'hF800_0000});
    vecs.push_back('{"srl",   2'b10, 5'b00101, 1'b0, 32'h8000_0000, 32'd4,  32'd0, 32'h0800_0000});
    vecs.push_back('{"srai",  2'b11, 5'b10101, 1'b1, 32'h8000_0000, 32'd0,  32'd4, 32'hF800_0000});
    vecs.push_back('{"sltu",  2'b10, 5'b00011, 1'b0, 32'hFFFF_FFFF, 32'd1,  32'd0, 32'd0});
    vecs.push_back('{"slt",   2'b10, 5'b00010, 1'b0, 32'hFFFF_FFFF, 32'd1,  32'd0, 32'd1});
    vecs.push_back('{"add_wrap", 2'b10, 5'b00000, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0});
    vecs.push_back('{"sub",   2'b10, 5'b10000, 1'b0, 32'd3, 32'd5, 32'd0, 32'hFFFF_FFFE});
    vecs.push_back('{"addi_i30", 2'b11, 5'b10000, 1'b1, 32'd10, 32'd0, 32'd3, 32'd13});
    vecs.push_back('{"sll",   2'b10, 5'b00001, 1'b0, 32'd1, 32'h23, 32'd0, 32'd8});
    vecs.push_back('{"xor",   2'b10, 5'b00100, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 32'hFF00});
    vecs.push_back('{"or",    2'b10, 5'b00110, 1'b0, 32'hF000, 32'h000F, 32'd0, 32'hF00F});
    vecs.push_back('{"and",   2'b10, 5'b00111, 1'b0, 32'hFF00, 32'h0FF0, 32'd0, 32'h0F00});
    vecs.push_back('{"ldst",  2'b00, 5'b10010, 1'b1, 32'h100, 32'h77, 32'h20, 32'h120});
    vecs.push_back('{"sltiu", 2'b11, 5'b00011, 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd1});
`ifndef EX_MUL_EN
    vecs.push_back('{"inst25_ignored", 2'b10, 5'b01000, 1'b0, 32'd6, 32'd7, 32'd0, 32'd13});
`endif
    foreach (vecs[i]) begin
      drive_op(vecs[i].op, vecs[i].funct, vecs[i].src, 5'd4, 5'd0, 5'd0, vecs[i].a, vecs[i].b, vecs[i].imm);
      step;
      compared++;
      if (ALU_resultM !== vecs[i].exp || store_dataM !== vecs[i].b) begin
        $display("FAIL alu_%s: got res=%h st=%h expected %h %h", vecs[i].name, ALU_resultM, store_dataM, vecs[i].exp, vecs[i].b);
        mismatched++;
      end
    end
    set_nop;
    step;
  endtask

`ifdef EX_MUL_EN
  task test_mul;
    int n;
    int bubbleErr;
    drive_op(2'b10, 5'b01000, 1'b0, 5'd7, 5'd0, 5'd0, 32'h1234_5678, 32'd3, 32'd0);
    #1;
    n = 0;
    bubbleErr = 0;
    while (stallE === 1'b1 && n < 200) begin
      step;
      n++;
      if (regWriteM !== 1'b0) bubbleErr++;
    end
    compared++;
    if (n !== MUL_CYCLES + 1) begin
      $display("FAIL mul_stall_len: got %0d expected %0d", n, MUL_CYCLES + 1);
      mismatched++;
    end
    compared++;
    if (bubbleErr !== 0) begin
      $display("FAIL mul_bubbles: got %0d non-bubble slots expected 0", bubbleErr);
      mismatched++;
    end
    step;
    compared++;
    if (ALU_resultM !== 32'h369D_0368 || regWriteM !== 1'b1 || write_regM !== 5'd7) begin
      $display("FAIL mul_result: got res=%h wr=%b rd=%0d expected 369d0368 1 7", ALU_resultM, regWriteM, write_regM);
      mismatched++;
    end
    set_nop;
    step;
    // reset while BUSY
    drive_op(2'b10, 5'b01000, 1'b0, 5'd7, 5'd0, 5'd0, 32'd9, 32'd9, 32'd0);
    step;
    step;
    compared++;
    if (mulStateDebug !== 2'd1 || stallE !== 1'b1) begin
      $display("FAIL mul_busy: got st=%0d stall=%b expected 1 1", mulStateDebug, stallE);
      mismatched++;
    end
    reset = 1'b0;
    step;
    reset = 1'b1;
    set_nop;
    #1;
    compared++;
    if (mulStateDebug !== 2'd0 || stallE !== 1'b0) begin
      $display("FAIL mul_reset_busy: got st=%0d stall=%b expected 0 0", mulStateDebug, stallE);
      mismatched++;
    end
    // MUL in the wrong-path slot after a taken branch never starts
    ALUopE = 2'b01; branchE = 1; functE = 5'b00000;
    read_dataE1 = 32'h5; read_dataE2 = 32'h5;
    step;
    drive_op(2'b10, 5'b01000, 1'b0, 5'd7, 5'd0, 5'd0, 32'd9, 32'd9, 32'd0);
    #1;
    compared++;
    if (stallE !== 1'b0) begin
      $display("FAIL mul_squash_stall: got %b expected 0", stallE);
      mismatched++;
    end
    step;
    set_nop;
    #1;
    compared++;
    if (mulStateDebug !== 2'd0 || regWriteM !== 1'b0) begin
      $display("FAIL mul_squash_state: got st=%0d wr=%b expected 0 0", mulStateDebug, regWriteM);
      mismatched++;
    end
    step;
  endtask
`endif

  initial begin
    reset = 1'b0;
    set_nop;
    step;
    step;
    test_reset;
    test_add;
    test_forwarding;
    test_back_to_back;
    test_branch;
    test_alu_ops;
`ifdef EX_MUL_EN
    test_mul;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
